sc_matrix_loader: RTL and testbench

SC_MATRIX_LOADER -- requirements
Module: sc_matrix_loader

---
 rtl/sc_matrix_loader_pkg.sv | 19 +
 rtl/sc_row_counter.sv | 37 +++
 rtl/sc_matrix_loader.sv | 111 +++++++++++
 tb/tb_sc_matrix_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_matrix_loader_pkg.sv
// Shared constants for the matrix loader: FSM encoding and row-counter sizing.
package sc_matrix_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned MIN_ROWS = 2;
  localparam int unsigned MAX_ROWS = 16;

  // Row counter width; never narrower than one bit.
  function automatic int unsigned row_cnt_w(input int unsigned rows);
    return (rows < 2) ? 1 : $clog2(rows);
  endfunction

endpackage

// File: rtl/sc_row_counter.sv
// Row index counter that wraps to zero after the last row and flags the last row.
module sc_row_counter
  import sc_matrix_loader_pkg::*;
#(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned CNT_W = row_cnt_w(ROWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(ROWS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST_VAL) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign value = cnt_q;
  assign last  = (cnt_q == LAST_VAL);

endmodule

// File: rtl/sc_matrix_loader.sv
// Frame loader: optional clear strobe, then one load strobe per row as source data arrives.
module sc_matrix_loader
  import sc_matrix_loader_pkg::*;
#(
  parameter int LOADER_DATAWIDTH = 8,
  parameter int LOADER_ROWS      = 8
) (
  input  logic                        SC_MATRIXLOADER_CLOCK_50,
  input  logic                        SC_MATRIXLOADER_RESET_InLow,
  input  logic                        SC_MATRIXLOADER_start_InLow,
  input  logic                        SC_MATRIXLOADER_clearFirst_InHigh,
  input  logic                        SC_MATRIXLOADER_abort_InLow,
  input  logic                        SC_MATRIXLOADER_valid_InHigh,
  input  logic [LOADER_DATAWIDTH-1:0] SC_MATRIXLOADER_data_InBUS,
  output logic                        SC_MATRIXLOADER_ready_OutHigh,
  output logic                        SC_MATRIXLOADER_clear_OutLow,
  output logic [LOADER_ROWS-1:0]      SC_MATRIXLOADER_load_OutLow,
  output logic [LOADER_DATAWIDTH-1:0] SC_MATRIXLOADER_data_OutBUS,
  output logic                        SC_MATRIXLOADER_busy_OutHigh,
  output logic                        SC_MATRIXLOADER_done_OutHigh
);

  localparam int unsigned CNT_W = row_cnt_w(LOADER_ROWS);

  state_e                      state_q, state_d;
  logic                        ready_q, ready_d;
  logic                        clear_n_q, clear_n_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [LOADER_ROWS-1:0]      load_n_q, load_n_d;
  logic [LOADER_DATAWIDTH-1:0] data_q, data_d;

  logic             cnt_en, cnt_clr, row_last;
  logic [CNT_W-1:0] row;

  sc_row_counter #(
    .ROWS  (LOADER_ROWS),
    .CNT_W (CNT_W)
  ) u_row_counter (
    .clk   (SC_MATRIXLOADER_CLOCK_50),
    .rst_n (SC_MATRIXLOADER_RESET_InLow),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .value (row),
    .last  (row_last)
  );

  always_comb begin
    state_d  = state_q;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
    load_n_d = '1;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (!SC_MATRIXLOADER_start_InLow) begin
          cnt_clr = 1'b1;
          state_d = SC_MATRIXLOADER_clearFirst_InHigh ? ST_CLEAR : ST_LOAD;
        end
      end
      ST_CLEAR: state_d = SC_MATRIXLOADER_abort_InLow ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        // Abort wins over a coincident transfer: the row is dropped, not strobed.
        if (!SC_MATRIXLOADER_abort_InLow) begin
          state_d = ST_IDLE;
        end else if (SC_MATRIXLOADER_valid_InHigh && ready_q) begin
          cnt_en        = 1'b1;
          load_n_d[row] = 1'b0;
          data_d        = SC_MATRIXLOADER_data_InBUS;
          if (row_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are decoded from the next state so they line up with it once registered.
    ready_d   = (state_d == ST_LOAD);
    clear_n_d = (state_d != ST_CLEAR);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge SC_MATRIXLOADER_CLOCK_50 or negedge SC_MATRIXLOADER_RESET_InLow) begin
    if (!SC_MATRIXLOADER_RESET_InLow) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      clear_n_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      load_n_q  <= '1;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      clear_n_q <= clear_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      load_n_q  <= load_n_d;
      data_q    <= data_d;
    end
  end

  assign SC_MATRIXLOADER_ready_OutHigh = ready_q;
  assign SC_MATRIXLOADER_clear_OutLow  = clear_n_q;
  assign SC_MATRIXLOADER_load_OutLow   = load_n_q;
  assign SC_MATRIXLOADER_data_OutBUS   = data_q;
  assign SC_MATRIXLOADER_busy_OutHigh  = busy_q;
  assign SC_MATRIXLOADER_done_OutHigh  = done_q;

endmodule

// File: tb/tb_sc_matrix_loader.sv
// Bench for sc_matrix_loader: frame-level reference model checked every cycle, plus directed literal checks.
module tb_sc_matrix_loader;

  localparam int DW = 8;
  localparam int R  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_n = 1'b1;
  logic          clr_first = 1'b0;
  logic          abort_n = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] din = '0;

  logic          ready, clear_n, busy, done;
  logic [R-1:0]  load_n;
  logic [DW-1:0] dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sc_matrix_loader #(
    .LOADER_DATAWIDTH (DW),
    .LOADER_ROWS      (R)
  ) dut (
    .SC_MATRIXLOADER_CLOCK_50          (clk),
    .SC_MATRIXLOADER_RESET_InLow       (rst_n),
    .SC_MATRIXLOADER_start_InLow       (start_n),
    .SC_MATRIXLOADER_clearFirst_InHigh (clr_first),
    .SC_MATRIXLOADER_abort_InLow       (abort_n),
    .SC_MATRIXLOADER_valid_InHigh      (valid),
    .SC_MATRIXLOADER_data_InBUS        (din),
    .SC_MATRIXLOADER_ready_OutHigh     (ready),
    .SC_MATRIXLOADER_clear_OutLow      (clear_n),
    .SC_MATRIXLOADER_load_OutLow       (load_n),
    .SC_MATRIXLOADER_data_OutBUS       (dout),
    .SC_MATRIXLOADER_busy_OutHigh      (busy),
    .SC_MATRIXLOADER_done_OutHigh      (done)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame-level reference: phase 0 waiting, 1 clearing, 2 loading rows, 3 frame finished.
  int            m_phase = 0;
  int            m_row   = 0;
  logic [R-1:0]  e_load  = '1;
  logic [DW-1:0] e_data  = '0;

  always @(posedge clk or negedge rst_n) begin : model
    int            ph, rw;
    logic [R-1:0]  ld;
    logic [DW-1:0] dt;
    if (!rst_n) begin
      m_phase <= 0;
      m_row   <= 0;
      e_load  <= '1;
      e_data  <= '0;
    end else begin
      ph = m_phase;
      rw = m_row;
      ld = '1;
      dt = e_data;
      case (ph)
        0: if (!start_n) begin rw = 0; ph = clr_first ? 1 : 2; end
        1: ph = abort_n ? 2 : 0;
        2: begin
          if (!abort_n) ph = 0;
          else if (valid) begin
            ld[rw] = 1'b0;
            dt     = din;
            if (rw == R - 1) begin rw = 0; ph = 3; end
            else rw = rw + 1;
          end
        end
        default: ph = 0;
      endcase
      m_phase <= ph;
      m_row   <= rw;
      e_load  <= ld;
      e_data  <= dt;
    end
  end

  always @(negedge clk) begin : compare
    check("m_ready", 32'(ready), 32'(m_phase == 2));
    check("m_clear", 32'(clear_n), 32'(m_phase != 1));
    check("m_busy", 32'(busy), 32'(m_phase != 0));
    check("m_done", 32'(done), 32'(m_phase == 3));
    check("m_load", 32'(load_n), 32'(e_load));
    check("m_data", 32'(dout), 32'(e_data));
    check("onecold", 32'($countones(~load_n) <= 1), 32'(1));
    check("clr_ld_excl", 32'(!clear_n && (load_n != '1)), 32'(0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [R-1:0] exp_ld;

    repeat (2) step();
    check("rst_load", 32'(load_n), 32'hFF);
    check("rst_clear", 32'(clear_n), 32'h1);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_data", 32'(dout), 32'h0);
    rst_n = 1'b1;
    step();

    // Clear-first frame, valid held high, data 1..8.
    start_n = 1'b0; clr_first = 1'b1; valid = 1'b1; din = 8'h01;
    step();
    check("s1_clear_lo", 32'(clear_n), 32'h0);
    check("s1_clear_busy", 32'(busy), 32'h1);
    check("s1_clear_rdy", 32'(ready), 32'h0);
    start_n = 1'b1; clr_first = 1'b0;
    step();
    check("s1_clear_hi", 32'(clear_n), 32'h1);
    check("s1_rdy", 32'(ready), 32'h1);
    check("s1_noload", 32'(load_n), 32'hFF);
    for (int i = 0; i < R; i++) begin
      step();
      exp_ld = ~(8'd1 << i);
      check("s1_load", 32'(load_n), 32'(exp_ld));
      check("s1_data", 32'(dout), 32'(i + 1));
      din = 8'(i + 2);
    end
    check("s1_done", 32'(done), 32'h1);
    check("s1_done_rdy", 32'(ready), 32'h0);
    valid = 1'b0;
    step();
    check("s1_idle_done", 32'(done), 32'h0);
    check("s1_idle_busy", 32'(busy), 32'h0);

    // No clear, valid toggling: strobes two cycles apart, data held in gaps.
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    check("s2_noclear", 32'(clear_n), 32'h1);
    check("s2_rdy", 32'(ready), 32'h1);
    for (int i = 0; i < R; i++) begin
      valid = 1'b1; din = 8'(8'hA0 + i);
      step();
      exp_ld = ~(8'd1 << i);
      check("s2_load", 32'(load_n), 32'(exp_ld));
      check("s2_data", 32'(dout), 32'(8'hA0 + i));
      valid = 1'b0; din = 8'h55;
      step();
      check("s2_gap_load", 32'(load_n), 32'hFF);
      check("s2_gap_data", 32'(dout), 32'(8'hA0 + i));
    end
    step();

    // Abort coinciding with the row-3 transfer.
    start_n = 1'b0; valid = 1'b1;
    step();
    start_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'h10 + i);
      step();
    end
    abort_n = 1'b0; din = 8'h13;
    step();
    check("s3_abort_load", 32'(load_n), 32'hFF);
    check("s3_abort_busy", 32'(busy), 32'h0);
    check("s3_abort_done", 32'(done), 32'h0);
    check("s3_abort_data", 32'(dout), 32'h12);
    abort_n = 1'b1; valid = 1'b0;
    step();
    check("s3_stay_idle", 32'(busy), 32'h0);
    start_n = 1'b0; valid = 1'b1; din = 8'h20;
    step();
    start_n = 1'b1;
    step();
    check("s3_restart_row0", 32'(load_n), 32'hFE);
    check("s3_restart_data", 32'(dout), 32'h20);
    repeat (8) step();
    valid = 1'b0;
    step();

    // Asynchronous reset during row 5.
    start_n = 1'b0; valid = 1'b1;
    step();
    start_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      din = 8'(8'h30 + i);
      step();
    end
    check("s4_row5", 32'(load_n), 32'hDF);
    #2 rst_n = 1'b0;
    #1;
    check("s4_rst_load", 32'(load_n), 32'hFF);
    check("s4_rst_data", 32'(dout), 32'h0);
    check("s4_rst_busy", 32'(busy), 32'h0);
    check("s4_rst_rdy", 32'(ready), 32'h0);
    check("s4_rst_clear", 32'(clear_n), 32'h1);
    check("s4_rst_done", 32'(done), 32'h0);
    step();
    rst_n = 1'b1;
    repeat (4) step();
    check("s4_after_busy", 32'(busy), 32'h0);
    check("s4_after_load", 32'(load_n), 32'hFF);
    valid = 1'b0;

    // Start held low through LOAD and DONE: restarts only from IDLE.
    start_n = 1'b0; valid = 1'b1;
    step();
    for (int i = 0; i < R; i++) begin
      din = 8'(8'h40 + i);
      step();
      exp_ld = ~(8'd1 << i);
      check("s5_load", 32'(load_n), 32'(exp_ld));
    end
    check("s5_done", 32'(done), 32'h1);
    step();
    check("s5_idle", 32'(busy), 32'h0);
    step();
    check("s5_newframe", 32'(ready), 32'h1);
    start_n = 1'b1; abort_n = 1'b0;
    step();
    abort_n = 1'b1; valid = 1'b0;
    step();

    // Randomized traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      start_n   = ($urandom_range(0, 7) != 0);
      clr_first = 1'($urandom_range(0, 1));
      abort_n   = ($urandom_range(0, 40) != 0);
      valid     = ($urandom_range(0, 3) != 0);
      din       = 8'($urandom);
      if ($urandom_range(0, 300) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
